// File: rtl/alu_mult_seq_pkg.sv
// Shared constants for the sequential multiplier:
// ALU function codes and multiplier FSM state encoding.
package alu_mult_seq_pkg;

    localparam logic [5:0] FN_ADD   = 6'd32;
    localparam logic [5:0] FN_SUB   = 6'd34;
    localparam logic [5:0] FN_AND   = 6'd36;
    localparam logic [5:0] FN_OR    = 6'd37;
    localparam logic [5:0] FN_SLT   = 6'd42;
    localparam logic [5:0] FN_MULTU = 6'd25;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/mult_seq_cnt.sv
// Iteration counter for the shift-and-add multiplier.
// Ports: clk, reset (async high), clr, en; tc_o high when count == WIDTH-1.
module mult_seq_cnt #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/alu_mult_seq.sv
// Sequences the shared external ALU to compute an unsigned
// WIDTH x WIDTH multiply (MULTU) by shift-and-add over WIDTH cycles.
// Ports: clk, reset (async high); start/funct/dataA/dataB request;
// busy/done/illegal status; hi/lo product; alu_a/alu_b/alu_signal
// drive the ALU, alu_result/alu_cout return its sum.
// Optional: define MULT_ZERO_SKIP_EN to finish at once on zero operands.
module alu_mult_seq
    import alu_mult_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [5:0]       alu_signal,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic             illegal_q, illegal_d;
    logic             is_idle, is_calc;
    logic             accept, zero_op, tc;

    assign is_idle = (state_q == S_IDLE);
    assign is_calc = (state_q == S_CALC);
    assign accept  = is_idle && start && (funct == FN_MULTU);

`ifdef MULT_ZERO_SKIP_EN
    assign zero_op = (dataA == '0) || (dataB == '0);
`else
    assign zero_op = 1'b0;
`endif

    mult_seq_cnt #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (is_idle),
        .en    (is_calc),
        .tc_o  (tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = zero_op ? S_DONE : S_CALC;
            S_CALC: if (tc) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy  = is_calc;
        done  = (state_q == S_DONE);
        alu_a = '0;
        alu_b = '0;
        if (is_calc) begin
            alu_a = hi_q;
            alu_b = lo_q[0] ? mcand_q : '0;
        end
    end

    assign alu_signal = FN_ADD;

    // Sum of partial and (multiplier bit ? mcand : 0), carry included,
    // shifts right one place into {hi,lo} consuming one multiplier bit.
    always_comb begin
        hi_d      = hi_q;
        lo_d      = lo_q;
        mcand_d   = mcand_q;
        illegal_d = is_idle && start && (funct != FN_MULTU);
        if (accept) begin
            mcand_d = dataA;
            hi_d    = '0;
            lo_d    = zero_op ? '0 : dataB;
        end else if (is_calc) begin
            {hi_d, lo_d} = {alu_cout, alu_result, lo_q[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            mcand_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            mcand_q   <= mcand_d;
            illegal_q <= illegal_d;
        end
    end

    assign hi      = hi_q;
    assign lo      = lo_q;
    assign illegal = illegal_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Self-checking bench for alu_mult_seq with an external ALU model
// and a cycle-level reference model of the multiply request.
module tb_alu_mult_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] dataA = '0;
    logic [31:0] dataB = '0;
    logic        busy, done, illegal;
    logic [31:0] hi, lo, alu_a, alu_b, alu_result;
    logic [5:0]  alu_signal;
    logic        alu_cout;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_mult_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .funct      (funct),
        .dataA      (dataA),
        .dataB      (dataB),
        .busy       (busy),
        .done       (done),
        .illegal    (illegal),
        .hi         (hi),
        .lo         (lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_signal (alu_signal),
        .alu_result (alu_result),
        .alu_cout   (alu_cout)
    );

    // external shared ALU: 33-bit add when asked for ADD
    assign {alu_cout, alu_result} = (alu_signal == 6'd32) ?
        ({1'b0, alu_a} + {1'b0, alu_b}) : 33'd0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // reference model: request-level behaviour
    int          m_left;
    bit          m_done, m_ill, m_valid, m_was_done;
    logic [63:0] m_prod;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_left = 0;
            m_done = 0;
            m_ill = 0;
            m_valid = 1;
            m_prod = 64'd0;
        end else begin
            m_was_done = m_done;
            m_done = 0;
            m_ill = 0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1;
                    m_valid = 1;
                end
            end else if (!m_was_done && start) begin
                if (funct == 6'd25) begin
                    m_prod = {32'd0, dataA} * {32'd0, dataB};
`ifdef MULT_ZERO_SKIP_EN
                    if (dataA == 0 || dataB == 0) begin
                        m_done = 1;
                        m_valid = 1;
                    end else begin
                        m_left = 32;
                        m_valid = 0;
                    end
`else
                    m_left = 32;
                    m_valid = 0;
`endif
                end else begin
                    m_ill = 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            check("busy", 64'(busy), 64'(m_left > 0));
            check("done", 64'(done), 64'(m_done));
            check("illegal", 64'(illegal), 64'(m_ill));
            check("busy_done_excl", 64'(busy & done), 64'd0);
            check("alu_signal", 64'(alu_signal), 64'd32);
            if (!busy) begin
                check("alu_a_idle", 64'(alu_a), 64'd0);
                check("alu_b_idle", 64'(alu_b), 64'd0);
            end
            if (m_valid) begin
                check("hi", 64'(hi), 64'(m_prod[63:32]));
                check("lo", 64'(lo), 64'(m_prod[31:0]));
            end
        end
    end

    task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output int nbusy);
        @(posedge clk);
        #2;
        start = 1'b1;
        funct = 6'd25;
        dataA = a;
        dataB = b;
        lat = 0;
        nbusy = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (busy) nbusy++;
            if (done) break;
        end
        check("done_seen", 64'(done), 64'd1);
    endtask

    int lat, nb;

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_alu_signal", 64'(alu_signal), 64'd32);
        #1;
        reset = 1'b0;

        // 3 x 5
        do_mult(32'd3, 32'd5, lat, nb);
        check("lat_3x5", 64'(lat), 64'd33);
        check("busy_cycles_3x5", 64'(nb), 64'd32);
        check("hi_3x5", 64'(hi), 64'd0);
        check("lo_3x5", 64'(lo), 64'd15);

        // start during the done cycle is ignored, no illegal pulse
        start = 1'b1;
        funct = 6'd34;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_start_illegal", 64'(illegal), 64'd0);
        check("done_start_busy", 64'(busy), 64'd0);

        // max operands: carry out of the ALU must be kept
        do_mult(32'hFFFFFFFF, 32'hFFFFFFFF, lat, nb);
        check("hi_max", 64'(hi), 64'hFFFFFFFE);
        check("lo_max", 64'(lo), 64'h00000001);

        // illegal funct
        @(posedge clk);
        #2;
        start = 1'b1;
        funct = 6'd32;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("ill_pulse", 64'(illegal), 64'd1);
        check("ill_busy", 64'(busy), 64'd0);
        check("ill_hi", 64'(hi), 64'hFFFFFFFE);
        check("ill_lo", 64'(lo), 64'h00000001);
        @(posedge clk);
        #1;
        check("ill_one_cycle", 64'(illegal), 64'd0);

        // second start during CALC is ignored
        @(posedge clk);
        #2;
        start = 1'b1;
        funct = 6'd25;
        dataA = 32'd3;
        dataB = 32'd5;
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            lat++;
            if (lat == 10) begin
                start = 1'b1;
                dataA = 32'd7;
            end
            if (done) break;
        end
        check("ign_lat", 64'(lat), 64'd33);
        check("ign_hi", 64'(hi), 64'd0);
        check("ign_lo", 64'(lo), 64'd15);

        // a few more products
        do_mult(32'h80000000, 32'd2, lat, nb);
        check("hi_msb", 64'(hi), 64'd1);
        check("lo_msb", 64'(lo), 64'd0);
        do_mult(32'h0001_0000, 32'h0001_0000, lat, nb);
        check("hi_2p16", 64'(hi), 64'd1);
        check("lo_2p16", 64'(lo), 64'd0);
        do_mult(32'd1234, 32'd5678, lat, nb);
        check("lo_1234", 64'(lo), 64'd7006652);

        // async reset at iteration 12
        @(posedge clk);
        #2;
        start = 1'b1;
        funct = 6'd25;
        dataA = 32'h12345678;
        dataB = 32'h9ABCDEF0;
        for (int i = 0; i < 13; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        #2;
        reset = 1'b1;
        #1;
        check("mrst_busy", 64'(busy), 64'd0);
        check("mrst_done", 64'(done), 64'd0);
        check("mrst_hi", 64'(hi), 64'd0);
        check("mrst_lo", 64'(lo), 64'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        do_mult(32'd6, 32'd7, lat, nb);
        check("hi_6x7", 64'(hi), 64'd0);
        check("lo_6x7", 64'(lo), 64'd42);

        // zero operand
        do_mult(32'd0, 32'd9, lat, nb);
`ifdef MULT_ZERO_SKIP_EN
        check("zero_lat", 64'(lat), 64'd1);
`else
        check("zero_lat", 64'(lat), 64'd33);
`endif
        check("zero_hi", 64'(hi), 64'd0);
        check("zero_lo", 64'(lo), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_mult_seq.md
Name: alu_mult_seq

Overview:
Multi-cycle controller that sequences the shared WIDTH-bit ripple ALU (array of 1-bit slices) to perform unsigned multiply (MULTU, funct 6'd25) by shift-and-add.
Owns the ALU operand/function inputs while busy and produces a 2×WIDTH product split into hi/lo.
Sits between the decode stage (start/funct/operands) and the HiLo register file.

Parameters:
WIDTH, 32, operand width; must match the ALU datapath width.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high; clears all state.
start  input  1  request pulse; sampled only in IDLE.
funct  input  6  function code; only 6'd25 (MULTU) accepted.
dataA  input  WIDTH  multiplicand.
dataB  input  WIDTH  multiplier.
busy  output  1  high while in CALC.
done  output  1  one-cycle pulse when hi/lo become valid.
illegal  output  1  one-cycle pulse when start arrives with funct != 6'd25.
hi  output  WIDTH  upper product word; held until next accepted start.
lo  output  WIDTH  lower product word; held until next accepted start.
alu_a  output  WIDTH  ALU operand A.
alu_b  output  WIDTH  ALU operand B.
alu_signal  output  6  ALU function code; fixed at ADD, 6'd32.
alu_result  input  WIDTH  ALU sum.
alu_cout  input  1  ALU carry-out of MSB slice.

Behaviour:
- Clock and reset: one clock `clk`; reset `reset` is asynchronous, active-high.
- Reset values: state=IDLE; busy, done and illegal = 0; hi, lo, alu_a and alu_b = 0; alu_signal = 6'd32; counter = 0; internal multiplicand register = 0.
- States: IDLE, CALC, DONE.
- IDLE, start=1, funct=25:
  - latch mcand<=dataA, lo<=dataB, hi<=0, cnt<=0; go to CALC.
- IDLE, start=1, funct!=25:
  - illegal=1 for the next cycle only; stay in IDLE; hi/lo unchanged.
- CALC, combinational ALU drive: alu_a=hi; alu_b = lo[0] ? mcand : 0; alu_signal=32.
- CALC, each clock:
  - {hi,lo} <= {alu_cout, alu_result, lo[WIDTH-1:1]}, i.e. the (WIDTH+1)-bit sum is shifted right one place into the concatenation;
  - cnt <= cnt+1;
  - when cnt==WIDTH-1, go to DONE.
- Outside CALC, alu_a and alu_b are driven to 0.
- DONE: done=1 for exactly one cycle; busy=0; return to IDLE.
- Timing: start sampled at edge E0 → busy high for WIDTH cycles → done high during the cycle after edge E(WIDTH).
  - Next start is accepted at the edge ending the done cycle or later; start in DONE is ignored.
- start while busy or in DONE: ignored, no illegal pulse.
- busy and done are never high together.
- hi/lo during CALC hold partial products; they are valid only from the done cycle until the next accepted start.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- Arithmetic: the carry is never dropped; the full 2×WIDTH product is exact for all unsigned inputs.

Optional Feature:
Macro MULT_ZERO_SKIP_EN.
- Defined: in IDLE, an accepted MULTU with dataA==0 or dataB==0 skips CALC.
  - hi<=0, lo<=0, go directly to DONE; done appears in the cycle after the start edge.
  - busy never asserts for that request.
- Undefined: zero operands take the full WIDTH-cycle path, with identical results.

Decomposition:
- Shared package holds:
  - funct constants: FN_ADD=6'd32, FN_SUB=6'd34, FN_AND=6'd36, FN_OR=6'd37, FN_SLT=6'd42, FN_MULTU=6'd25;
  - the state encoding localparams, S_IDLE=2'd0, S_CALC=2'd1, S_DONE=2'd2.
- Sub-module mult_seq_cnt: iteration counter with clear, enable and terminal-count output.
- The ALU itself stays external and shared; no copy lives inside this block.

Test Plan:
- dataA=3, dataB=5, MULTU → done 33 cycles after start edge; hi=0, lo=15; busy high exactly 32 cycles.
- dataA=dataB=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001; checks carry capture via alu_cout.
- funct=6'd32 with start → illegal pulses 1 cycle; busy stays 0; hi/lo keep prior values.
- Second start asserted at cycle 10 of CALC with dataA=7 → ignored; first result 3×5=15 is unaffected.
- reset asserted asynchronously mid-cycle at iteration 12 → busy, done, hi and lo are 0 immediately; new MULTU 6×7 then yields lo=42.
- With MULT_ZERO_SKIP_EN, dataA=0, dataB=9 → done in the next cycle, busy never high, hi=lo=0; without the macro, done after 33 cycles with the same result.
